// File: rtl/ysyx_22041412_irq_ctrl.sv
// Machine-mode trap/interrupt controller.
// It holds mstatus/mie/mtvec/mepc/mcause/mip. It takes the timer interrupt or
// an ecall when an instruction retires, handles mret, and issues one fetch
// redirect per trap or return.
module ysyx_22041412_irq_ctrl #(
  parameter logic [63:0] MTVEC_RST = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtip_i,
  input  logic        commit_valid_i,
  output logic        commit_ready_o,
  input  logic [63:0] commit_pc_i,
  input  logic [63:0] next_pc_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  output logic [63:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRAP = 2'd1;
  localparam logic [1:0] ST_RET  = 2'd2;

  // CSR table: index 0..5 = mstatus, mie, mtvec, mepc, mcause, mip
  localparam int NCSR = 6;
  localparam logic [NCSR*12-1:0] CSR_ADDR_TBL =
    {12'h344, 12'h342, 12'h341, 12'h305, 12'h304, 12'h300};
  localparam int CSR_MSTATUS = 0;
  localparam int CSR_MIE     = 1;
  localparam int CSR_MTVEC   = 2;
  localparam int CSR_MEPC    = 3;
  localparam int CSR_MCAUSE  = 4;

  // The low two PC bits are always zero in mtvec (direct mode) and mepc
  localparam logic [63:0] PC_MASK = ~64'd3;

  logic [1:0]  state_reg, state_next;
  logic        mie_reg, mie_next;      // mstatus.MIE
  logic        mpie_reg, mpie_next;    // mstatus.MPIE
  logic        mtie_reg, mtie_next;    // mie.MTIE
  logic        mtip_reg;               // mip.MTIP
  logic [63:0] mtvec_reg, mtvec_next;
  logic [63:0] mepc_reg, mepc_next;
  logic [63:0] mcause_reg, mcause_next;

  logic                  retire;
  logic                  pend;
  logic [NCSR-1:0]       csr_hit;
  logic [NCSR-1:0]       csr_wr;
  logic [NCSR-1:0][63:0] csr_val;
  logic [NCSR-1:0][63:0] csr_sel_val;

  assign commit_ready_o = (state_reg == ST_IDLE);
  assign retire         = commit_valid_i & commit_ready_o;
  assign pend           = mie_reg & mtie_reg & mtip_reg;

  // Architectural read views of each CSR
  assign csr_val[0] = {51'd0, 2'b11, 3'd0, mpie_reg, 3'd0, mie_reg, 3'd0};
  assign csr_val[1] = {56'd0, mtie_reg, 7'd0};
  assign csr_val[2] = mtvec_reg;
  assign csr_val[3] = mepc_reg;
  assign csr_val[4] = mcause_reg;
  assign csr_val[5] = {56'd0, mtip_reg, 7'd0};

  generate
    for (genvar gi = 0; gi < NCSR; gi++) begin : g_csr
      assign csr_hit[gi]     = (csr_addr_i == CSR_ADDR_TBL[gi*12 +: 12]);
      assign csr_wr[gi]      = retire & csr_we_i & csr_hit[gi];
      assign csr_sel_val[gi] = csr_hit[gi] ? csr_val[gi] : 64'd0;
    end
  endgenerate

  assign csr_illegal_o = ~|csr_hit;

  // One-hot OR-mux of the addressed CSR; unmapped addresses read zero
  always_comb begin
    csr_rdata_o = 64'd0;
    for (int i = 0; i < NCSR; i++) begin
      csr_rdata_o = csr_rdata_o | csr_sel_val[i];
    end
  end

  // The redirect target is a pure function of state so it stays stable while stalled
  always_comb begin
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 64'd0;
    if (state_reg == ST_TRAP) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = mtvec_reg & PC_MASK;
    end else if (state_reg == ST_RET) begin
      redirect_valid_o = 1'b1;
      redirect_pc_o    = mepc_reg;
    end
  end

  // Next-state: CSR write first, then trap/ecall/mret field updates override it
  always_comb begin
    state_next  = state_reg;
    mie_next    = mie_reg;
    mpie_next   = mpie_reg;
    mtie_next   = mtie_reg;
    mtvec_next  = mtvec_reg;
    mepc_next   = mepc_reg;
    mcause_next = mcause_reg;
    if (retire) begin
      if (csr_wr[CSR_MSTATUS]) begin
        mie_next  = csr_wdata_i[3];
        mpie_next = csr_wdata_i[7];
      end
      if (csr_wr[CSR_MIE])    mtie_next   = csr_wdata_i[7];
      if (csr_wr[CSR_MTVEC])  mtvec_next  = csr_wdata_i & PC_MASK;
      if (csr_wr[CSR_MEPC])   mepc_next   = csr_wdata_i & PC_MASK;
      if (csr_wr[CSR_MCAUSE]) mcause_next = csr_wdata_i;
      if (pend) begin
        // Interrupt: resume at the instruction after the one that retired
        mepc_next   = next_pc_i & PC_MASK;
        mcause_next = {1'b1, 63'd7};
        mpie_next   = mie_reg;
        mie_next    = 1'b0;
        state_next  = ST_TRAP;
      end else if (ecall_i) begin
        mepc_next   = commit_pc_i & PC_MASK;
        mcause_next = 64'd11;
        mpie_next   = mie_reg;
        mie_next    = 1'b0;
        state_next  = ST_TRAP;
      end else if (mret_i) begin
        mie_next    = mpie_reg;
        mpie_next   = 1'b1;
        state_next  = ST_RET;
      end
    end else if ((state_reg != ST_IDLE) && redirect_ready_i) begin
      state_next = ST_IDLE;
    end
  end

  // State and CSR registers; mip.MTIP samples the timer line every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mie_reg    <= 1'b0;
      mpie_reg   <= 1'b0;
      mtie_reg   <= 1'b0;
      mtip_reg   <= 1'b0;
      mtvec_reg  <= MTVEC_RST;
      mepc_reg   <= 64'd0;
      mcause_reg <= 64'd0;
    end else begin
      state_reg  <= state_next;
      mie_reg    <= mie_next;
      mpie_reg   <= mpie_next;
      mtie_reg   <= mtie_next;
      mtip_reg   <= mtip_i;
      mtvec_reg  <= mtvec_next;
      mepc_reg   <= mepc_next;
      mcause_reg <= mcause_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_irq_ctrl.sv
// Scoreboard bench for ysyx_22041412_irq_ctrl. Stimulus updates an
// architectural model and queues the expected redirects and CSR reads. A
// negedge monitor pops the queues and compares them against the DUT.
module tb_ysyx_22041412_irq_ctrl;

  localparam logic [63:0] MTVEC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mtip_i = 1'b0;
  logic        commit_valid_i = 1'b0;
  logic        commit_ready_o;
  logic [63:0] commit_pc_i = 64'd0;
  logic [63:0] next_pc_i = 64'd0;
  logic        ecall_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = 12'd0;
  logic [63:0] csr_wdata_i = 64'd0;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i = 1'b0;

  ysyx_22041412_irq_ctrl #(.MTVEC_RST(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .mtip_i(mtip_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_pc_i(commit_pc_i), .next_pc_i(next_pc_i),
    .ecall_i(ecall_i), .mret_i(mret_i),
    .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- architectural model ----------------
  bit          m_mie, m_mpie, m_mtie, m_mip;
  logic [63:0] m_mtvec, m_mepc, m_mcause;

  // mip.MTIP shows the timer line as it was one clock earlier
  always @(posedge clk) m_mip <= rst ? 1'b0 : mtip_i;

  function automatic bit model_legal(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h305) ||
           (a == 12'h341) || (a == 12'h342) || (a == 12'h344);
  endfunction

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_mie ? 64'h8 : 64'h0);
      12'h304: return m_mtie ? 64'h80 : 64'h0;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip ? 64'h80 : 64'h0;
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0;
    m_mtvec = MTVEC_RST; m_mepc = 64'd0; m_mcause = 64'd0;
  endtask

  // ---------------- scoreboard queues ----------------
  typedef struct packed {
    logic [11:0] addr;
    logic [63:0] data;
    logic        ill;
  } rd_t;

  logic [63:0] redir_q[$];
  rd_t         rd_q[$];
  logic        rd_req = 1'b0;

  // Monitor: redirect targets, commit handshake and CSR reads, sampled mid-cycle
  always @(negedge clk) begin
    if (redirect_valid_o) begin
      check("commit_ready_in_redirect", {63'd0, commit_ready_o}, 64'd0);
      if (redir_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect actual_pc=%h required=no_redirect", redirect_pc_o);
      end else begin
        check("redirect_pc", redirect_pc_o, redir_q[0]);
        if (redirect_ready_i) void'(redir_q.pop_front());
      end
    end else begin
      check("commit_ready_idle", {63'd0, commit_ready_o}, 64'd1);
    end
    if (rd_req) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL csr_read_queue actual=empty required=entry");
      end else begin
        rd_t e;
        e = rd_q.pop_front();
        check($sformatf("csr_rdata_%h", e.addr), csr_rdata_o, e.data);
        check($sformatf("csr_illegal_%h", e.addr), {63'd0, csr_illegal_o}, {63'd0, e.ill});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] a);
    rd_t e;
    e.addr = a;
    e.data = model_read(a);
    e.ill  = !model_legal(a);
    csr_addr_i = a;
    rd_q.push_back(e);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // One retire from IDLE; hold = stall cycles before ready (-1 = random), abort = reset during redirect
  task automatic retire(input logic [63:0] cpc, input logic [63:0] npc, input bit ec, input bit mr,
                        input bit we, input logic [11:0] a, input logic [63:0] wd,
                        input int hold, input bit abort);
    bit old_mie, old_mpie, pend, redir;
    int n;
    old_mie  = m_mie;
    old_mpie = m_mpie;
    pend     = m_mie && m_mtie && m_mip;
    redir    = 0;
    if (we) begin
      case (a)
        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h304: m_mtie = wd[7];
        12'h305: m_mtvec = wd & ~64'd3;
        12'h341: m_mepc = wd & ~64'd3;
        12'h342: m_mcause = wd;
        default: ;
      endcase
    end
    if (pend) begin
      m_mepc = npc & ~64'd3; m_mcause = 64'h8000_0000_0000_0007;
      m_mpie = old_mie; m_mie = 0;
      redir_q.push_back(m_mtvec); redir = 1;
    end else if (ec) begin
      m_mepc = cpc & ~64'd3; m_mcause = 64'd11;
      m_mpie = old_mie; m_mie = 0;
      redir_q.push_back(m_mtvec); redir = 1;
    end else if (mr) begin
      m_mie = old_mpie; m_mpie = 1;
      redir_q.push_back(m_mepc); redir = 1;
    end
    $display("retire pc=%h ecall=%0d mret=%0d we=%0d addr=%h pend=%0d redirect=%0d",
             cpc, ec, mr, we, a, pend, redir);
    commit_pc_i = cpc; next_pc_i = npc; ecall_i = ec; mret_i = mr;
    csr_we_i = we; csr_addr_i = a; csr_wdata_i = wd; commit_valid_i = 1'b1;
    tick();
    commit_valid_i = 1'b0; ecall_i = 1'b0; mret_i = 1'b0; csr_we_i = 1'b0;
    if (!redir) return;
    if (abort) begin
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      redir_q.delete();
      @(negedge clk);
      check("rst_abort_redirect_valid", {63'd0, redirect_valid_o}, 64'd0);
      tick();
      return;
    end
    n = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
    repeat (n) begin
      // A retire offered while stalled must be ignored
      commit_valid_i = 1'b1; mret_i = 1'b1; csr_we_i = 1'b1;
      csr_addr_i = 12'h300; csr_wdata_i = '1;
      tick();
    end
    commit_valid_i = 1'b0; mret_i = 1'b0; csr_we_i = 1'b0;
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check("redirect_drained", 64'(redir_q.size()), 64'd0);
  endtask

  task automatic set_mtip(input bit v);
    mtip_i = v;
    tick();
  endtask

  logic [11:0] addr_tbl [7];

  initial begin
    addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
    model_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset values and an unmapped address
    read_csr(12'h305);
    read_csr(12'h344);
    read_csr(12'h7C0);
    read_csr(12'h300);

    // Timer interrupt path, with the redirect stalled for three cycles
    retire(64'h8000_0000, 64'h8000_0004, 0, 0, 1, 12'h304, 64'h80, 0, 0);
    retire(64'h8000_0004, 64'h8000_0008, 0, 0, 1, 12'h300, 64'h8, 0, 0);
    set_mtip(1);
    retire(64'h8000_0100, 64'h8000_0104, 0, 0, 0, 12'h000, 64'h0, 3, 0);
    read_csr(12'h341);
    read_csr(12'h342);
    read_csr(12'h300);

    // ecall with interrupts disabled, then mret back to the ecall PC
    set_mtip(0);
    retire(64'h8000_0200, 64'h8000_0204, 1, 0, 0, 12'h000, 64'h0, 1, 0);
    read_csr(12'h342);
    read_csr(12'h341);
    retire(64'h8000_0300, 64'h8000_0304, 0, 1, 0, 12'h000, 64'h0, 0, 0);
    read_csr(12'h300);

    // Pending only once MIE and MTIE are both set on pre-update values
    retire(64'h8000_0400, 64'h8000_0404, 0, 0, 1, 12'h304, 64'h0, 0, 0);
    set_mtip(1);
    retire(64'h8000_0408, 64'h8000_040C, 0, 0, 0, 12'h000, 64'h0, 0, 0);
    read_csr(12'h344);
    retire(64'h8000_040C, 64'h8000_0410, 0, 0, 1, 12'h304, 64'h80, 0, 0);
    retire(64'h8000_0410, 64'h8000_0414, 0, 0, 1, 12'h300, 64'h8, 0, 0);
    retire(64'h8000_0414, 64'h8000_0418, 0, 0, 0, 12'h000, 64'h0, 2, 0);
    read_csr(12'h342);

    // Reset while in TRAP aborts the redirect
    retire(64'h8000_0500, 64'h8000_0504, 1, 0, 0, 12'h000, 64'h0, 0, 1);
    for (int i = 0; i < 7; i++) read_csr(addr_tbl[i]);

    // Randomized retires
    for (int k = 0; k < 200; k++) begin
      int op;
      logic [63:0] pc;
      logic [63:0] wd;
      if ($urandom_range(0, 3) == 0) set_mtip(1'($urandom));
      op = $urandom_range(0, 5);
      pc = {32'h0, $urandom} & ~64'd3;
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) wd[3] = 1'b1;
      if ($urandom_range(0, 2) == 0) wd[7] = 1'b1;
      retire(pc, pc + 64'd4, (op == 1) || (op == 5), (op == 2) || (op == 5),
             (op >= 3), addr_tbl[$urandom_range(0, 6)], wd, -1, 0);
      read_csr(addr_tbl[$urandom_range(0, 6)]);
    end

    check("final_redirect_queue", 64'(redir_q.size()), 64'd0);
    check("final_read_queue", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22041412_irq_ctrl.md
YSYX_22041412_IRQ_CTRL -- requirements
Module: ysyx_22041412_irq_ctrl

Interface
REQ-001 The block SHALL have parameter MTVEC_RST, default 64'h8000_0000, giving the mtvec reset value.
REQ-002 The block SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have input mtip_i, 1 bit: level timer interrupt from the machine timer.
REQ-005 The block SHALL have input commit_valid_i, 1 bit: an instruction retires this cycle.
REQ-006 The block SHALL have output commit_ready_o, 1 bit: commit accepted; a retire occurs only when valid and ready are both high.
REQ-007 The block SHALL have inputs commit_pc_i and next_pc_i, each 64 bits: PC of the retiring instruction and its sequential successor.
REQ-008 The block SHALL have inputs ecall_i and mret_i, each 1 bit: qualify the retiring instruction.
REQ-009 The block SHALL have inputs csr_we_i (1 bit), csr_addr_i (12 bits) and csr_wdata_i (64 bits): CSR write qualified by the retire.
REQ-010 The block SHALL have output csr_rdata_o, 64 bits: combinational read of CSR csr_addr_i.
REQ-011 The block SHALL have output csr_illegal_o, 1 bit: csr_addr_i is unmapped.
REQ-012 The block SHALL have output redirect_valid_o, 1 bit: fetch redirect request.
REQ-013 The block SHALL have output redirect_pc_o, 64 bits: redirect target.
REQ-014 The block SHALL have input redirect_ready_i, 1 bit: fetch accepts the redirect.

Function
REQ-015 The block SHALL implement these CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342 and mip 0x344; all other addresses read 0 and set csr_illegal_o.
REQ-016 mstatus SHALL implement MIE (bit 3) and MPIE (bit 7); MPP (bits 12:11) SHALL read 2'b11; all other bits SHALL read 0 and ignore writes.
REQ-017 mie SHALL implement only MTIE (bit 7); mip SHALL implement only MTIP (bit 7), which is read-only.
REQ-018 mip.MTIP SHALL be a register loaded from mtip_i every cycle, giving 1 cycle of latency.
REQ-019 mtvec SHALL operate in direct mode only: bits [1:0] read 0 and writes to them are ignored. mepc bits [1:0] SHALL also read 0.
REQ-020 Interrupt pending SHALL be defined as pend = mstatus.MIE & mie.MTIE & mip.MTIP, evaluated on pre-update register values.
REQ-021 The FSM SHALL have states IDLE, TRAP and RET; commit_ready_o SHALL be 1 only in IDLE.
REQ-022 In IDLE, a retire with pend=1 SHALL take the interrupt:
  - mepc <= next_pc_i
  - mcause <= {1'b1, 63'd7}
  - MPIE <= MIE, MIE <= 0
  - go to TRAP
REQ-023 In IDLE, a retire with pend=0 and ecall_i=1 SHALL take the exception:
  - mepc <= commit_pc_i
  - mcause <= 64'd11
  - MPIE <= MIE, MIE <= 0
  - go to TRAP
REQ-024 In IDLE, a retire with pend=0, ecall_i=0 and mret_i=1 SHALL:
  - set MIE <= MPIE, MPIE <= 1
  - go to RET
REQ-025 If ecall_i and mret_i are both set on a retire, ecall SHALL win.
REQ-026 CSR writes SHALL be applied only on an IDLE retire with csr_we_i=1; trap, ecall and mret field updates on the same edge SHALL override the write to the same fields.
REQ-027 In TRAP, redirect_valid_o SHALL be 1 with redirect_pc_o = {mtvec[63:2], 2'b00}.
REQ-028 In RET, redirect_valid_o SHALL be 1 with redirect_pc_o = mepc.
REQ-029 redirect_valid_o and redirect_pc_o SHALL remain stable until redirect_ready_i=1; on that edge the FSM SHALL return to IDLE.
REQ-030 redirect_valid_o SHALL be 0 in IDLE, so redirect latency is exactly 1 cycle after the retire edge.
REQ-031 Interrupts SHALL be taken only at retire; mtip_i asserted while no retire occurs SHALL remain pending until the next retire.
REQ-032 mtip_i deasserting before a retire SHALL cancel the interrupt, with no latching beyond mip.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL return to this state:
  - state = IDLE
  - mstatus.MIE = MPIE = 0
  - mie = 0, mip = 0
  - mtvec = MTVEC_RST
  - mepc = 0, mcause = 0
REQ-034 During and after reset, outputs SHALL be redirect_valid_o = 0 and commit_ready_o = 1.
REQ-035 Reset asserted in TRAP or RET SHALL abort the pending redirect immediately, so redirect_valid_o = 0 on the next cycle.

Verification
REQ-036 Scenario: reset, then read 0x305 -> csr_rdata_o = 64'h8000_0000; read 0x344 -> 0; read 0x7C0 -> csr_illegal_o = 1.
REQ-037 Scenario: write mie = 0x80 and mstatus = 0x8, hold mtip_i = 1, retire with next_pc_i = 0x8000_0104 -> next cycle:
  - redirect_valid_o = 1, redirect_pc_o = 0x8000_0000
  - mepc = 0x8000_0104
  - mcause = 0x8000_0000_0000_0007
  - mstatus reads 0x1880
REQ-038 Scenario: hold redirect_ready_i = 0 for 3 cycles -> redirect_valid_o and redirect_pc_o stay constant and commit_ready_o = 0; a retire presented meanwhile is not accepted.
REQ-039 Scenario: ecall at commit_pc_i = 0x8000_0200 with MIE = 0 -> mcause = 11, mepc = 0x8000_0200; then mret -> redirect_pc_o = 0x8000_0200 and mstatus.MIE = 0, MPIE = 1.
REQ-040 Scenario: mtip_i = 1 with mie.MTIE = 0 -> no trap on retire, mip reads 0x80; on a retire that writes mstatus MIE = 1, no trap occurs on that retire; with mie.MTIE set, the trap occurs on the next retire.
REQ-041 Scenario: assert rst during TRAP -> redirect_valid_o = 0 and all CSRs hold their reset values on the next cycle.
